// File: rtl/lru_pkg.sv
// Shared types and constants for the LRU request feeder slice.
package lru_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BUSY = 2'd1,
      S_WAIT_IDLE = 2'd2
   } feeder_state_e;

   localparam logic [1:0]  LRU_ST_IDLE = 2'd0;
   localparam int unsigned LRU_DATA_W  = 8;

endpackage

// File: rtl/lru_req_fifo.sv
// Synchronous DEPTH x DATA_W request FIFO; push is refused when full, pop when empty.
module lru_req_fifo
   import lru_pkg::*;
#(
   parameter int unsigned DATA_W = LRU_DATA_W,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; reset empties the FIFO through the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/lru_request_feeder.sv
// Paces a byte stream into the 4-entry LRU buffer, one held request at a time.
// Optional watchdog enabled by defining LRU_FEEDER_TIMEOUT_EN.
module lru_request_feeder
   import lru_pkg::*;
#(
   parameter int unsigned DATA_W      = LRU_DATA_W,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TIMEOUT_CYC = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   input  logic [1:0]                 lru_state,
   output logic                       lru_valid,
   output logic [DATA_W-1:0]          lru_data,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [15:0]                issued_cnt,
   output logic                       timeout_err
);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 2");
   end

   feeder_state_e     state_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [15:0]       issued_q;
   logic [DATA_W-1:0] head;
   logic              fifo_full, fifo_empty;
   logic              issue, wdog_expire;

   assign issue = (state_q == S_IDLE) && !fifo_empty && (lru_state == LRU_ST_IDLE);

   lru_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (in_valid),
      .push_data_i (in_data),
      .pop_i       (issue),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign in_ready   = !fifo_full;
   assign lru_valid  = valid_q;
   assign lru_data   = data_q;
   assign issued_cnt = issued_q;

   // WAIT_BUSY absorbs the cycle before the buffer's registered state reflects the request.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         valid_q  <= 1'b0;
         data_q   <= '0;
         issued_q <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: if (issue) begin
               data_q   <= head;
               valid_q  <= 1'b1;
               issued_q <= issued_q + 16'd1;
               state_q  <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (lru_state != LRU_ST_IDLE) state_q <= S_WAIT_IDLE;
            S_WAIT_IDLE: if (lru_state == LRU_ST_IDLE) state_q <= S_IDLE;
            default:     state_q <= S_IDLE;
         endcase
         if (wdog_expire) state_q <= S_IDLE;
      end
   end

`ifdef LRU_FEEDER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_q;
   logic          terr_q;

   assign wdog_expire = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));
   assign timeout_err = terr_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_q  <= '0;
         terr_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
         tmo_q <= '0;
      end else if (wdog_expire) begin
         tmo_q  <= '0;
         terr_q <= 1'b1;
      end else begin
         tmo_q <= tmo_q + TW'(1);
      end
   end
`else
   assign wdog_expire = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lru_request_feeder.sv
// Directed bench for lru_request_feeder: cycle vector table plus multi-cycle sequences.
module tb_lru_request_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [1:0] lru_state;
   logic       lru_valid;
   logic [7:0] lru_data;
   logic [3:0] fifo_count;
   logic [15:0] issued_cnt;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   logic        model_en = 1'b0;
   int unsigned busy_len = 10;
   logic [1:0]  tb_st = 2'd0;
   logic [1:0]  model_st = 2'd0;
   int unsigned rem = 0;
   logic [7:0]  pulses[$];
   logic [7:0]  hold = 8'h00;
   logic        prev_valid = 1'b0;

   always #5 clk = ~clk;

   lru_request_feeder #(.DATA_W(8), .DEPTH(8), .TIMEOUT_CYC(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .lru_state   (lru_state),
      .lru_valid   (lru_valid),
      .lru_data    (lru_data),
      .fifo_count  (fifo_count),
      .issued_cnt  (issued_cnt),
      .timeout_err (timeout_err)
   );

   assign lru_state = model_en ? model_st : tb_st;

   // LRU buffer model: registered state goes busy the edge after a request, for busy_len cycles.
   always @(posedge clk) begin
      if (!rst) begin
         model_st <= 2'd0;
         rem      <= 0;
      end else if (lru_valid) begin
         model_st <= 2'd1;
         rem      <= busy_len;
      end else if (rem > 1) begin
         rem <= rem - 1;
      end else begin
         rem      <= 0;
         model_st <= 2'd0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && model_en) begin
         if (lru_valid) begin
            pulses.push_back(lru_data);
            hold = lru_data;
            chk("pulse_width", {31'd0, prev_valid}, 32'd0);
         end
         if (lru_state != 2'd0) begin
            chk("data_hold", {24'd0, lru_data}, {24'd0, hold});
            chk("no_pulse_busy", {31'd0, lru_valid}, 32'd0);
         end
      end
      prev_valid = lru_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic push(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic        in_v;
      logic [7:0]  d;
      logic [1:0]  st;
      logic        exp_v;
      logic [7:0]  exp_d;
      logic [3:0]  exp_cnt;
      logic        exp_rdy;
      logic [15:0] exp_iss;
   } vec_t;

   vec_t tbl[16];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not end in time");
      $fatal(1, "global timeout");
   end

   initial begin
      tbl[0]  = '{1'b1, 8'h5A, 2'd0, 1'b0, 8'h00, 4'd1, 1'b1, 16'd0};
      tbl[1]  = '{1'b0, 8'h00, 2'd0, 1'b1, 8'h5A, 4'd0, 1'b1, 16'd1};
      tbl[2]  = '{1'b1, 8'h11, 2'd0, 1'b0, 8'h5A, 4'd1, 1'b1, 16'd1};
      tbl[3]  = '{1'b1, 8'h22, 2'd1, 1'b0, 8'h5A, 4'd2, 1'b1, 16'd1};
      tbl[4]  = '{1'b0, 8'h00, 2'd1, 1'b0, 8'h5A, 4'd2, 1'b1, 16'd1};
      tbl[5]  = '{1'b0, 8'h00, 2'd0, 1'b0, 8'h5A, 4'd2, 1'b1, 16'd1};
      tbl[6]  = '{1'b0, 8'h00, 2'd0, 1'b1, 8'h11, 4'd1, 1'b1, 16'd2};
      tbl[7]  = '{1'b1, 8'h33, 2'd0, 1'b0, 8'h11, 4'd2, 1'b1, 16'd2};
      tbl[8]  = '{1'b0, 8'h00, 2'd1, 1'b0, 8'h11, 4'd2, 1'b1, 16'd2};
      tbl[9]  = '{1'b0, 8'h00, 2'd0, 1'b0, 8'h11, 4'd2, 1'b1, 16'd2};
      tbl[10] = '{1'b0, 8'h00, 2'd1, 1'b0, 8'h11, 4'd2, 1'b1, 16'd2};
      tbl[11] = '{1'b0, 8'h00, 2'd0, 1'b1, 8'h22, 4'd1, 1'b1, 16'd3};
      tbl[12] = '{1'b0, 8'h00, 2'd1, 1'b0, 8'h22, 4'd1, 1'b1, 16'd3};
      tbl[13] = '{1'b0, 8'h00, 2'd0, 1'b0, 8'h22, 4'd1, 1'b1, 16'd3};
      tbl[14] = '{1'b1, 8'h44, 2'd0, 1'b1, 8'h33, 4'd1, 1'b1, 16'd4};
      tbl[15] = '{1'b0, 8'h00, 2'd0, 1'b0, 8'h33, 4'd1, 1'b1, 16'd4};

      // Reset held with in_valid asserted.
      rst = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ready", {31'd0, in_ready}, 32'd1);
         chk("rst_count", {28'd0, fifo_count}, 32'd0);
         chk("rst_valid", {31'd0, lru_valid}, 32'd0);
         chk("rst_data", {24'd0, lru_data}, 32'd0);
      end
      chk("rst_issued", {16'd0, issued_cnt}, 32'd0);
      chk("rst_terr", {31'd0, timeout_err}, 32'd0);
      rst = 1'b1;

      // Cycle-accurate vectors with lru_state driven directly.
      for (int i = 0; i < 16; i++) begin
         in_valid = tbl[i].in_v;
         in_data  = tbl[i].d;
         tb_st    = tbl[i].st;
         tick();
         chk($sformatf("v%0d_valid", i), {31'd0, lru_valid}, {31'd0, tbl[i].exp_v});
         chk($sformatf("v%0d_data", i), {24'd0, lru_data}, {24'd0, tbl[i].exp_d});
         chk($sformatf("v%0d_count", i), {28'd0, fifo_count}, {28'd0, tbl[i].exp_cnt});
         chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
         chk($sformatf("v%0d_issued", i), {16'd0, issued_cnt}, {16'd0, tbl[i].exp_iss});
      end
      in_valid = 1'b0;
      tb_st = 2'd0;

      // Three requests against a 10-cycle busy LRU model.
      do_reset();
      model_en = 1'b1;
      busy_len = 10;
      pulses.delete();
      push(8'h11);
      chk("lat_before", {31'd0, lru_valid}, 32'd0);
      push(8'h22);
      chk("lat_valid", {31'd0, lru_valid}, 32'd1);
      chk("lat_data", {24'd0, lru_data}, 32'h11);
      push(8'h33);
      for (int t = 0; t < 200 && pulses.size() < 3; t++) tick();
      for (int t = 0; t < 15; t++) tick();
      chk("three_npulses", pulses.size(), 32'd3);
      if (pulses.size() == 3) begin
         chk("three_p0", {24'd0, pulses[0]}, 32'h11);
         chk("three_p1", {24'd0, pulses[1]}, 32'h22);
         chk("three_p2", {24'd0, pulses[2]}, 32'h33);
      end
      chk("three_issued", {16'd0, issued_cnt}, 32'd3);

      // Fill the FIFO while the LRU is stalled busy; the 9th push must be dropped.
      do_reset();
      model_en = 1'b0;
      tb_st = 2'd1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data = 8'hA0 + 8'(i);
         tick();
         chk($sformatf("fill%0d_count", i), {28'd0, fifo_count}, (i < 8) ? (i + 1) : 8);
         chk($sformatf("fill%0d_ready", i), {31'd0, in_ready}, (i < 7) ? 1 : 0);
      end
      in_valid = 1'b0;
      chk("fill_no_issue", {16'd0, issued_cnt}, 32'd0);
      pulses.delete();
      busy_len = 1;
      model_en = 1'b1;
      for (int t = 0; t < 100 && pulses.size() < 8; t++) tick();
      for (int t = 0; t < 10; t++) tick();
      chk("drain_npulses", pulses.size(), 32'd8);
      for (int k = 0; k < 8 && k < pulses.size(); k++)
         chk($sformatf("drain_p%0d", k), {24'd0, pulses[k]}, 32'hA0 + k);
      chk("drain_count", {28'd0, fifo_count}, 32'd0);
      chk("drain_issued", {16'd0, issued_cnt}, 32'd8);

      // Reset in the middle of a request with three bytes still queued.
      do_reset();
      busy_len = 10;
      pulses.delete();
      push(8'hC1);
      push(8'hC2);
      push(8'hC3);
      push(8'hC4);
      chk("mid_count_pre", {28'd0, fifo_count}, 32'd3);
      rst = 1'b0;
      tick();
      chk("mid_count", {28'd0, fifo_count}, 32'd0);
      chk("mid_valid", {31'd0, lru_valid}, 32'd0);
      chk("mid_data", {24'd0, lru_data}, 32'd0);
      chk("mid_issued", {16'd0, issued_cnt}, 32'd0);
      chk("mid_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b1;
      for (int t = 0; t < 6; t++) tick();
      chk("mid_discard", {16'd0, issued_cnt}, 32'd0);
      chk("mid_npulses", pulses.size(), 32'd1);
      push(8'hD7);
      tick();
      chk("mid_idle_valid", {31'd0, lru_valid}, 32'd1);
      chk("mid_idle_data", {24'd0, lru_data}, 32'hD7);

      // Watchdog behaviour with the LRU stuck busy.
      do_reset();
      model_en = 1'b0;
      tb_st = 2'd0;
      push(8'h5B);
      tick();
      chk("wd_issue", {31'd0, lru_valid}, 32'd1);
      tb_st = 2'd1;
`ifdef LRU_FEEDER_TIMEOUT_EN
      for (int t = 0; t < 31; t++) tick();
      chk("wd_before", {31'd0, timeout_err}, 32'd0);
      tick();
      chk("wd_err", {31'd0, timeout_err}, 32'd1);
      push(8'h6C);
      tick();
      chk("wd_hold_busy", {31'd0, lru_valid}, 32'd0);
      tb_st = 2'd0;
      tick();
      chk("wd_reissue_valid", {31'd0, lru_valid}, 32'd1);
      chk("wd_reissue_data", {24'd0, lru_data}, 32'h6C);
      chk("wd_issued", {16'd0, issued_cnt}, 32'd2);
      chk("wd_sticky", {31'd0, timeout_err}, 32'd1);
`else
      for (int t = 0; t < 40; t++) tick();
      chk("wd_off_err", {31'd0, timeout_err}, 32'd0);
      push(8'h6C);
      tick();
      chk("wd_off_wait", {31'd0, lru_valid}, 32'd0);
      tb_st = 2'd0;
      tick();
      chk("wd_off_still_wait", {31'd0, lru_valid}, 32'd0);
      tick();
      chk("wd_off_issue", {31'd0, lru_valid}, 32'd1);
      chk("wd_off_data", {24'd0, lru_data}, 32'h6C);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
